// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer.
//
// Instructions allocate an entry at the tail in program order. Functional units
// write results back by entry id, and the head entry retires once its result is
// present. Operand lookups read stored results for forwarding.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   alloc, alloc_rd, alloc_is_store
//                                 allocation request and its instruction info
//   full, alloc_rob_id            no free entry / id granted to the request (tail)
//   {alu,mem,mul}_wb_valid/_rob_id/_data
//                                 writeback ports, priority alu > mem > mul
//   rs1_rob_entry, rs2_rob_entry  operand lookup ids
//   rob_s1/s2_valid, rob_s1/s2_data
//                                 lookup result (entry busy and ready) and data
//   commit, commit_rd, commit_rob_id, commit_is_store
//                                 head retirement info
//   wenable_rf, reg_in, din       register-file write port
//   flush                         discard all uncommitted entries

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif
`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif

module reorder_buffer #(
    parameter int unsigned WORD_SIZE = `WORD_SIZE,
    parameter int unsigned N_ENTRIES = 2 ** `ROB_ENTRY_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              alloc,
    input  logic [`ARCH_REG_INDEX_SIZE-1:0]   alloc_rd,
    input  logic                              alloc_is_store,
    output logic                              full,
    output logic [`ROB_ENTRY_WIDTH-1:0]       alloc_rob_id,

    input  logic                              alu_wb_valid,
    input  logic [`ROB_ENTRY_WIDTH-1:0]       alu_wb_rob_id,
    input  logic [WORD_SIZE-1:0]              alu_wb_data,
    input  logic                              mem_wb_valid,
    input  logic [`ROB_ENTRY_WIDTH-1:0]       mem_wb_rob_id,
    input  logic [WORD_SIZE-1:0]              mem_wb_data,
    input  logic                              mul_wb_valid,
    input  logic [`ROB_ENTRY_WIDTH-1:0]       mul_wb_rob_id,
    input  logic [WORD_SIZE-1:0]              mul_wb_data,

    input  logic [`ROB_ENTRY_WIDTH-1:0]       rs1_rob_entry,
    input  logic [`ROB_ENTRY_WIDTH-1:0]       rs2_rob_entry,
    output logic [WORD_SIZE-1:0]              rob_s1_data,
    output logic [WORD_SIZE-1:0]              rob_s2_data,
    output logic                              rob_s1_valid,
    output logic                              rob_s2_valid,

    output logic                              commit,
    output logic [`ARCH_REG_INDEX_SIZE-1:0]   commit_rd,
    output logic [`ROB_ENTRY_WIDTH-1:0]       commit_rob_id,
    output logic                              wenable_rf,
    output logic [4:0]                        reg_in,
    output logic [WORD_SIZE-1:0]              din,
    output logic                              commit_is_store,

    input  logic                              flush
);

    localparam int unsigned IdW  = `ROB_ENTRY_WIDTH;
    localparam int unsigned RegW = `ARCH_REG_INDEX_SIZE;
    localparam int unsigned CntW = $clog2(N_ENTRIES + 1);

    logic [IdW-1:0]                       head_q, head_d;
    logic [IdW-1:0]                       tail_q, tail_d;
    logic [CntW-1:0]                      count_q, count_d;
    logic [N_ENTRIES-1:0]                 busy_q, busy_d;
    logic [N_ENTRIES-1:0]                 ready_q, ready_d;
    logic [N_ENTRIES-1:0]                 store_q, store_d;
    logic [N_ENTRIES-1:0][RegW-1:0]       rd_q, rd_d;
    logic [N_ENTRIES-1:0][WORD_SIZE-1:0]  data_q, data_d;

    logic alloc_ok;

    function automatic logic [IdW-1:0] ptr_inc(input logic [IdW-1:0] p);
        return (p == IdW'(N_ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full         = (count_q == CntW'(N_ENTRIES));
    assign alloc_rob_id = tail_q;
    assign alloc_ok     = alloc && !full && !flush;

    // Commit looks only at registered state, so a writeback lands one cycle
    // before its entry can retire.
    assign commit = busy_q[head_q] && ready_q[head_q] && !flush;

    always_comb begin
        commit_rob_id   = '0;
        commit_rd       = '0;
        reg_in          = '0;
        din             = '0;
        commit_is_store = 1'b0;
        wenable_rf      = 1'b0;
        if (commit) begin
            commit_rob_id   = head_q;
            commit_rd       = rd_q[head_q];
            reg_in          = 5'(rd_q[head_q]);
            din             = data_q[head_q];
            commit_is_store = store_q[head_q];
            wenable_rf      = !store_q[head_q] && (rd_q[head_q] != '0);
        end
    end

    assign rob_s1_valid = busy_q[rs1_rob_entry] && ready_q[rs1_rob_entry];
    assign rob_s2_valid = busy_q[rs2_rob_entry] && ready_q[rs2_rob_entry];
    assign rob_s1_data  = data_q[rs1_rob_entry];
    assign rob_s2_data  = data_q[rs2_rob_entry];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        store_d = store_q;
        rd_d    = rd_q;
        data_d  = data_q;

        if (flush) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Lowest priority first so a higher-priority port overwrites on a tie.
            if (mul_wb_valid && busy_q[mul_wb_rob_id]) begin
                ready_d[mul_wb_rob_id] = 1'b1;
                data_d[mul_wb_rob_id]  = mul_wb_data;
            end
            if (mem_wb_valid && busy_q[mem_wb_rob_id]) begin
                ready_d[mem_wb_rob_id] = 1'b1;
                data_d[mem_wb_rob_id]  = mem_wb_data;
            end
            if (alu_wb_valid && busy_q[alu_wb_rob_id]) begin
                ready_d[alu_wb_rob_id] = 1'b1;
                data_d[alu_wb_rob_id]  = alu_wb_data;
            end

            if (commit) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = ptr_inc(head_q);
            end

            // Allocation last: it wins over any writeback aimed at the tail.
            if (alloc_ok) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = 1'b0;
                rd_d[tail_q]    = alloc_rd;
                store_d[tail_q] = alloc_is_store;
                tail_d          = ptr_inc(tail_q);
            end

            unique case ({alloc_ok, commit})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            ready_q <= '0;
            store_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            store_q <= store_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: randomized scoreboard bench for reorder_buffer.
// The reference model keeps the in-flight instructions as an ordered queue;
// retirements it predicts are pushed to an expectation queue that a separate
// monitor pops whenever the DUT asserts commit.

module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc;
    logic [4:0]  alloc_rd;
    logic        alloc_is_store;
    logic        full;
    logic [2:0]  alloc_rob_id;
    logic        alu_wb_valid, mem_wb_valid, mul_wb_valid;
    logic [2:0]  alu_wb_rob_id, mem_wb_rob_id, mul_wb_rob_id;
    logic [31:0] alu_wb_data, mem_wb_data, mul_wb_data;
    logic [2:0]  rs1_rob_entry, rs2_rob_entry;
    logic [31:0] rob_s1_data, rob_s2_data;
    logic        rob_s1_valid, rob_s2_valid;
    logic        commit;
    logic [4:0]  commit_rd;
    logic [2:0]  commit_rob_id;
    logic        wenable_rf;
    logic [4:0]  reg_in;
    logic [31:0] din;
    logic        commit_is_store;
    logic        flush;

    reorder_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .alloc          (alloc),
        .alloc_rd       (alloc_rd),
        .alloc_is_store (alloc_is_store),
        .full           (full),
        .alloc_rob_id   (alloc_rob_id),
        .alu_wb_valid   (alu_wb_valid),
        .alu_wb_rob_id  (alu_wb_rob_id),
        .alu_wb_data    (alu_wb_data),
        .mem_wb_valid   (mem_wb_valid),
        .mem_wb_rob_id  (mem_wb_rob_id),
        .mem_wb_data    (mem_wb_data),
        .mul_wb_valid   (mul_wb_valid),
        .mul_wb_rob_id  (mul_wb_rob_id),
        .mul_wb_data    (mul_wb_data),
        .rs1_rob_entry  (rs1_rob_entry),
        .rs2_rob_entry  (rs2_rob_entry),
        .rob_s1_data    (rob_s1_data),
        .rob_s2_data    (rob_s2_data),
        .rob_s1_valid   (rob_s1_valid),
        .rob_s2_valid   (rob_s2_valid),
        .commit         (commit),
        .commit_rd      (commit_rd),
        .commit_rob_id  (commit_rob_id),
        .wenable_rf     (wenable_rf),
        .reg_in         (reg_in),
        .din            (din),
        .commit_is_store(commit_is_store),
        .flush          (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  id;
        logic [4:0]  rd;
        logic        st;
        logic        done;
        logic [31:0] data;
    } ent_t;

    ent_t inflight[$];   // program order, oldest first
    ent_t exp_q[$];      // predicted retirement awaiting the DUT
    int   next_id;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one writeback to the model if the target is in flight.
    task automatic model_wb(input logic [2:0] id, input logic [31:0] d);
        for (int i = 0; i < inflight.size(); i++) begin
            if (inflight[i].id == id) begin
                inflight[i].done = 1'b1;
                inflight[i].data = d;
            end
        end
    endtask

    // Reference model: advances on each clock edge from the inputs held stable
    // across the edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight.delete();
            exp_q.delete();
            next_id = 0;
        end else if (flush) begin
            inflight.delete();
            exp_q.delete();
            next_id = 0;
        end else begin
            bit was_full;
            bit retire;
            was_full = (inflight.size() == 8);
            retire   = (inflight.size() > 0) && inflight[0].done;
            if (alu_wb_valid) model_wb(alu_wb_rob_id, alu_wb_data);
            if (mem_wb_valid && !(alu_wb_valid && alu_wb_rob_id == mem_wb_rob_id))
                model_wb(mem_wb_rob_id, mem_wb_data);
            if (mul_wb_valid && !(alu_wb_valid && alu_wb_rob_id == mul_wb_rob_id)
                             && !(mem_wb_valid && mem_wb_rob_id == mul_wb_rob_id))
                model_wb(mul_wb_rob_id, mul_wb_data);
            if (retire) begin
                chk("commit_missing", 64'(exp_q.size()), 64'd0);
                exp_q.delete();
                void'(inflight.pop_front());
            end
            if (alloc && !was_full) begin
                ent_t e;
                e.id   = 3'(next_id);
                e.rd   = alloc_rd;
                e.st   = alloc_is_store;
                e.done = 1'b0;
                e.data = '0;
                inflight.push_back(e);
                next_id = (next_id + 1) % 8;
            end
        end
        if (inflight.size() > 0 && inflight[0].done && exp_q.size() == 0)
            exp_q.push_back(inflight[0]);
    end

    task automatic lookup(input logic [2:0] id, output logic v, output logic [31:0] d);
        v = 1'b0;
        d = '0;
        foreach (inflight[i]) begin
            if (inflight[i].id == id && inflight[i].done) begin
                v = 1'b1;
                d = inflight[i].data;
            end
        end
    endtask

    // Monitor: samples DUT outputs mid-cycle.
    always @(negedge clk) begin
        logic        v;
        logic [31:0] d;
        chk("full", 64'(full), 64'(inflight.size() == 8));
        chk("alloc_rob_id", 64'(alloc_rob_id), 64'(next_id));
        lookup(rs1_rob_entry, v, d);
        chk("rob_s1_valid", 64'(rob_s1_valid), 64'(v));
        if (v) chk("rob_s1_data", 64'(rob_s1_data), 64'(d));
        lookup(rs2_rob_entry, v, d);
        chk("rob_s2_valid", 64'(rob_s2_valid), 64'(v));
        if (v) chk("rob_s2_data", 64'(rob_s2_data), 64'(d));
        if (commit) begin
            if (exp_q.size() == 0) begin
                chk("commit_unexpected", 64'(commit), 64'd0);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("commit_rob_id", 64'(commit_rob_id), 64'(e.id));
                chk("commit_rd", 64'(commit_rd), 64'(e.rd));
                chk("reg_in", 64'(reg_in), 64'(e.rd));
                chk("din", 64'(din), 64'(e.data));
                chk("commit_is_store", 64'(commit_is_store), 64'(e.st));
                chk("wenable_rf", 64'(wenable_rf), 64'(!e.st && e.rd != 0));
            end
        end else begin
            chk("idle_commit_outputs",
                {27'd0, wenable_rf, commit_is_store, reg_in, din, commit_rd, commit_rob_id},
                64'd0);
        end
    end

    task automatic idle();
        alloc = 0; alloc_rd = 0; alloc_is_store = 0; flush = 0;
        alu_wb_valid = 0; mem_wb_valid = 0; mul_wb_valid = 0;
        alu_wb_rob_id = 0; mem_wb_rob_id = 0; mul_wb_rob_id = 0;
        alu_wb_data = 0; mem_wb_data = 0; mul_wb_data = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] pick_id();
        if (inflight.size() > 0 && $urandom_range(3) != 0)
            return inflight[$urandom_range(inflight.size() - 1)].id;
        return 3'($urandom_range(7));
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_alloc_rob_id"}, 64'(alloc_rob_id), 64'd0);
        chk({tag, "_commit"}, 64'(commit), 64'd0);
        chk({tag, "_wenable_rf"}, 64'(wenable_rf), 64'd0);
        chk({tag, "_din"}, 64'(din), 64'd0);
        chk({tag, "_rob_s1"}, {31'd0, rob_s1_valid, rob_s1_data}, 64'd0);
        chk({tag, "_rob_s2"}, {31'd0, rob_s2_valid, rob_s2_data}, 64'd0);
    endtask

    initial begin
        idle();
        rs1_rob_entry = 3'd2;
        rs2_rob_entry = 3'd0;
        rst = 1'b0;
        #12;
        check_reset_outputs("reset");
        rst = 1'b1;
        cyc();

        // Single instruction round trip.
        alloc = 1; alloc_rd = 5'd3; cyc();
        alloc = 0; alu_wb_valid = 1; alu_wb_rob_id = 0; alu_wb_data = 32'h2A; cyc();
        idle(); cyc(); cyc();

        // Fill, overflow attempt, then free a slot while allocation is requested.
        for (int i = 0; i < 9; i++) begin
            alloc = 1; alloc_rd = 5'(i + 1); cyc();
        end
        alloc = 0; alu_wb_valid = 1; alu_wb_rob_id = 1; alu_wb_data = 32'h11; cyc();
        alu_wb_valid = 0; alloc = 1; alloc_rd = 5'd9; cyc();
        cyc();
        for (int i = 0; i < 8; i++) begin
            alloc = 0; mul_wb_valid = 1; mul_wb_rob_id = 3'(i); mul_wb_data = 32'(i * 7); cyc();
        end
        idle(); flush = 1; cyc(); flush = 0;

        // Out-of-order writeback, lookup on id 2 around its writeback.
        alloc = 1; alloc_rd = 5'd4; cyc();
        alloc_rd = 5'd5; cyc();
        alloc_rd = 5'd6; cyc();
        alloc = 0; alu_wb_valid = 1; alu_wb_rob_id = 1; alu_wb_data = 32'h77; cyc();
        alu_wb_rob_id = 2; alu_wb_data = 32'h55;
        mem_wb_valid = 1; mem_wb_rob_id = 2; mem_wb_data = 32'h99; cyc();
        mem_wb_valid = 0; alu_wb_rob_id = 0; alu_wb_data = 32'h33; cyc();
        idle(); cyc(); cyc(); cyc();

        // Store and rd=0 retire without a register write.
        alloc = 1; alloc_rd = 5'd0; alloc_is_store = 1; cyc();
        alloc_is_store = 0; cyc();
        alloc = 0; mem_wb_valid = 1; mem_wb_rob_id = 3'(next_id - 2 + 8); mem_wb_data = 32'hAB;
        cyc();
        mem_wb_rob_id = 3'(next_id - 1 + 8); mem_wb_data = 32'hCD; cyc();
        idle(); cyc(); cyc();

        // Flush with three entries, one of them ready at the head.
        alloc = 1; cyc(); cyc(); cyc();
        alloc = 0; alu_wb_valid = 1; alu_wb_rob_id = inflight[0].id; alu_wb_data = 32'h5; cyc();
        idle(); flush = 1; alloc = 1; cyc();
        idle(); alloc = 1; alloc_rd = 5'd1; cyc();
        idle();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            alloc          = ($urandom_range(2) != 0);
            alloc_rd       = 5'($urandom_range(31));
            alloc_is_store = ($urandom_range(3) == 0);
            alu_wb_valid   = ($urandom_range(2) == 0);
            mem_wb_valid   = ($urandom_range(2) == 0);
            mul_wb_valid   = ($urandom_range(2) == 0);
            alu_wb_rob_id  = pick_id();
            mem_wb_rob_id  = ($urandom_range(3) == 0) ? alu_wb_rob_id : pick_id();
            mul_wb_rob_id  = ($urandom_range(3) == 0) ? mem_wb_rob_id : pick_id();
            alu_wb_data    = $urandom;
            mem_wb_data    = $urandom;
            mul_wb_data    = $urandom;
            rs1_rob_entry  = 3'($urandom_range(7));
            rs2_rob_entry  = pick_id();
            flush          = ($urandom_range(59) == 0);
            cyc();
        end

        // Reset mid-traffic: outputs clear without waiting for a clock edge.
        idle();
        alloc = 1; alloc_rd = 5'd7; cyc(); cyc();
        alu_wb_valid = 1; alu_wb_rob_id = inflight[0].id; alu_wb_data = 32'hDEAD;
        rs1_rob_entry = inflight[0].id; cyc();
        idle();
        #1 rst = 1'b0;
        #1 check_reset_outputs("midrst");
        #4 rst = 1'b1;
        cyc();
        alloc = 1; alloc_rd = 5'd2; cyc();
        alloc = 0; mem_wb_valid = 1; mem_wb_rob_id = 0; mem_wb_data = 32'h1234; cyc();
        idle(); cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
